// File: rtl/cpu16_seq_ctrl_if.sv
// Instruction-memory fetch port between cpu16_seq_ctrl (master) and instruction memory (slave).
interface cpu16_seq_ctrl_if;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [15:0] IMEM_DATA;

    modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_ACK, input IMEM_DATA);
    modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_ACK, output IMEM_DATA);
endinterface

// File: rtl/cpu16_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer driving the CPU16 ALU selects and register file.
// Define CPU16_STEP_EN to add the STEP input: one instruction per STEP pulse, RUN ignored.
module cpu16_seq_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        RUN,
`ifdef CPU16_STEP_EN
    input  logic        STEP,
`endif
    cpu16_seq_ctrl_if.master imem,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic [3:0]  N1,
    output logic [3:0]  N2,
    output logic [3:0]  WN,
    output logic        REG_WE,
    output logic        B_SEL_IMM,
    output logic [15:0] IMM,
    output logic        S_SUB,
    output logic        S_FAS,
    output logic        S_AND,
    output logic        S_OR,
    output logic        S_XOR,
    output logic        S_NOT,
    output logic        BUSY,
    output logic        HALTED,
    output logic [1:0]  FAULT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] to_cnt;
    logic [6:0]  sel_q;
    logic        go;
    logic        cont;
    logic        dec_ok;
    logic        dec_halt;
    logic [6:0]  dec_sel;

`ifdef CPU16_STEP_EN
    assign go   = STEP;
    assign cont = 1'b0;
`else
    assign go   = RUN;
    assign cont = RUN;
`endif

    // dec_sel packs {S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT, B_SEL_IMM}
    always_comb begin
        dec_ok   = 1'b1;
        dec_halt = 1'b0;
        dec_sel  = '0;
        case (IR[15:12])
            4'h0: begin
                case (IR[7:4])
                    4'hA:    dec_sel = 7'b0100000;
                    4'h2:    dec_sel = 7'b1100000;
                    4'hC:    dec_sel = 7'b0010000;
                    4'hE:    dec_sel = 7'b0001000;
                    4'hD:    dec_sel = 7'b0000100;
                    4'hB:    dec_sel = 7'b0000010;
                    default: dec_ok  = 1'b0;
                endcase
            end
            4'h4:    dec_sel  = 7'b0100001;
            4'hF:    dec_halt = 1'b1;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            PC     <= RESET_PC;
            IR     <= '0;
            WN     <= '0;
            REG_WE <= 1'b0;
            sel_q  <= '0;
            FAULT  <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (go) state <= ST_FETCH;
                end
                // An ACK in the last allowed cycle is still accepted
                ST_FETCH: begin
                    if (imem.IMEM_ACK) begin
                        IR     <= imem.IMEM_DATA;
                        to_cnt <= '0;
                        state  <= ST_DECODE;
                    end else if (to_cnt == TO_LAST) begin
                        FAULT <= 2'b10;
                        state <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_DECODE: begin
                    if (dec_halt) begin
                        PC    <= PC + 16'd1;
                        state <= ST_HALT;
                    end else if (dec_ok) begin
                        sel_q <= dec_sel;
                        state <= ST_EXEC;
                    end else begin
                        FAULT <= 2'b01;
                        state <= ST_ERR;
                    end
                end
                ST_EXEC: begin
                    REG_WE <= 1'b1;
                    WN     <= IR[11:8];
                    state  <= ST_WB;
                end
                ST_WB: begin
                    REG_WE <= 1'b0;
                    sel_q  <= '0;
                    PC     <= PC + 16'd1;
                    to_cnt <= '0;
                    state  <= cont ? ST_FETCH : ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign {S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT, B_SEL_IMM} = sel_q;

    assign imem.IMEM_REQ  = (state == ST_FETCH);
    assign imem.IMEM_ADDR = PC;
    assign N1     = IR[11:8];
    assign N2     = IR[3:0];
    assign IMM    = {{8{IR[7]}}, IR[7:0]};
    assign BUSY   = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXEC)  || (state == ST_WB);
    assign HALTED = (state == ST_HALT);

endmodule
